// File: rtl/shift_sched.sv
// Two-requester round-robin barrel-free shifter: one 2^k stage per cycle,
// with early-out for out-of-range amounts and optionally for zero amounts.
module shift_sched #(
  parameter bit EARLY_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_mode,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_c,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] w_q, w_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  mode_q, mode_d;
  logic        sign_q, sign_d;
  logic        id_q, id_d;
  logic        last_q, last_d;

  logic        gnt0, gnt1;
  logic [31:0] sel_a, sel_b;
  logic [1:0]  sel_mode;
  logic [4:0]  sh;
  logic [31:0] fill, sh_l, sh_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      sign_q  <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Stage k moves the word by 2^k; SRA fills with the latched sign bit.
  always_comb begin
    sh   = 5'd1 << k_q;
    fill = (mode_q == 2'b10) ? {32{sign_q}} : '0;
    sh_l = w_q << sh;
    sh_r = (w_q >> sh) | (fill & ~({32{1'b1}} >> sh));
  end

  always_comb begin
    gnt0     = req0_valid && (!req1_valid || last_q);
    gnt1     = req1_valid && !gnt0;
    sel_a    = gnt1 ? req1_a : req0_a;
    sel_b    = gnt1 ? req1_b : req0_b;
    sel_mode = gnt1 ? req1_mode : req0_mode;
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    w_d        = w_q;
    amt_d      = amt_q;
    mode_d     = mode_q;
    sign_d     = sign_q;
    id_d       = id_q;
    last_d     = last_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0 && !rst;
        req1_ready = gnt1 && !rst;
        if (gnt0 || gnt1) begin
          last_d = gnt1;
          id_d   = gnt1;
          amt_d  = sel_b[4:0];
          mode_d = sel_mode;
          sign_d = sel_a[31];
          k_d    = '0;
          if (|sel_b[31:5]) begin
            state_d = DONE;
            w_d = (sel_mode == 2'b10) ? {32{sel_a[31]}} : '0;
          end else if (EARLY_ZERO && sel_b == '0) begin
            state_d = DONE;
            w_d     = sel_a;
          end else begin
            state_d = SHIFT;
            w_d     = sel_a;
          end
        end
      end
      SHIFT: begin
        if (amt_q[k_q]) w_d = (mode_q == 2'b00) ? sh_l : sh_r;
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = DONE;
          k_d     = '0;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_valid = (state_q == DONE);
  assign resp_c     = w_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Bench for shift_sched: two instances (EARLY_ZERO 0/1) on shared inputs,
// table vectors, directed corner sequences and a random model check.
module tb_shift_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req1_valid, resp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_mode, req1_mode;

  logic        rdy0_a, rdy1_a, rv_a, rid_a, busy_a;
  logic        rdy0_b, rdy1_b, rv_b, rid_b, busy_b;
  logic [31:0] rc_a, rc_b;

  shift_sched #(.EARLY_ZERO(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy0_a),
    .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(rdy1_a),
    .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .resp_valid(rv_a), .resp_ready(resp_ready),
    .resp_id(rid_a), .resp_c(rc_a), .busy(busy_a)
  );

  shift_sched #(.EARLY_ZERO(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rdy0_b),
    .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(rdy1_b),
    .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .resp_valid(rv_b), .resp_ready(resp_ready),
    .resp_id(rid_b), .resp_c(rc_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_c(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [1:0] m);
    if (b >= 32) return (m == 2'b10) ? {32{a[31]}} : 32'h0;
    if (m == 2'b00) return a << b;
    if (m == 2'b10) return $unsigned($signed(a) >>> b);
    return a >> b;
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input bit ez);
    return (b >= 32 || (ez && b == 0)) ? 1 : 6;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic id, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] m,
                       input logic [31:0] ec, input int el0,
                       input int el1);
    int f0, f1;
    logic [31:0] c0, c1;
    logic i0;
    f0 = 0; f1 = 0; c0 = '0; c1 = '0; i0 = 1'b0;
    resp_ready = 1'b1;
    if (id) begin
      req1_a = a; req1_b = b; req1_mode = m; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_mode = m; req0_valid = 1'b1;
    end
    #1;
    chk("op_ready", id ? rdy1_a : rdy0_a, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (rv_a && f0 == 0) begin f0 = n; c0 = rc_a; i0 = rid_a; end
      if (rv_b && f1 == 0) begin f1 = n; c1 = rc_b; end
      step();
    end
    chk("lat_ez0", f0, el0);
    chk("res_ez0", c0, ec);
    chk("id_ez0", {31'b0, i0}, {31'b0, id});
    chk("lat_ez1", f1, el1);
    chk("res_ez1", c1, ec);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  m;
    logic [31:0] c;
    int          l0;
    int          l1;
  } vec_t;

  vec_t tv[12];

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rm;
    logic        rid;
    logic [31:0] got_c[4];
    logic        got_id[4];
    int          nresp;
    logic [31:0] hold_c;
    logic        hold_id;
    logic        stale;

    tv[0]  = '{1'b0, 32'h80000001, 32'd4, 2'b10, 32'hF8000000, 6, 6};
    tv[1]  = '{1'b1, 32'h000000FF, 32'h20, 2'b00, 32'h0, 1, 1};
    tv[2]  = '{1'b1, 32'h80000000, 32'h20, 2'b10, 32'hFFFFFFFF, 1, 1};
    tv[3]  = '{1'b0, 32'h12345678, 32'd8, 2'b00, 32'h34567800, 6, 6};
    tv[4]  = '{1'b1, 32'hF0000000, 32'd31, 2'b01, 32'h1, 6, 6};
    tv[5]  = '{1'b0, 32'hF0000000, 32'd31, 2'b11, 32'h1, 6, 6};
    tv[6]  = '{1'b1, 32'h80000000, 32'd31, 2'b10, 32'hFFFFFFFF, 6, 6};
    tv[7]  = '{1'b0, 32'h0000ABCD, 32'd0, 2'b01, 32'h0000ABCD, 6, 1};
    tv[8]  = '{1'b1, 32'h00000001, 32'hFFFFFFFF, 2'b00, 32'h0, 1, 1};
    tv[9]  = '{1'b0, 32'h80000000, 32'h80000020, 2'b10, 32'hFFFFFFFF, 1, 1};
    tv[10] = '{1'b1, 32'h7FFFFFFF, 32'h40, 2'b10, 32'h0, 1, 1};
    tv[11] = '{1'b0, 32'h00000001, 32'd31, 2'b00, 32'h80000000, 6, 6};

    // Reset state, with both requesters already asking.
    rst = 1'b1;
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'd1; req0_mode = 2'b00;
    req1_valid = 1'b1; req1_a = 32'h80000000; req1_b = 32'd3;
    req1_mode = 2'b10;
    #2;
    chk("rst_valid", rv_a, 0);
    chk("rst_c", rc_a, 0);
    chk("rst_id", rid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rdy0", rdy0_a, 0);
    chk("rst_rdy1", rdy1_a, 0);
    step();
    rst = 1'b0;
    #1;
    chk("first_rdy0", rdy0_a, 1);
    chk("first_rdy1", rdy1_a, 0);

    // Round-robin with both held valid.
    nresp = 0;
    for (int n = 0; n < 60 && nresp < 4; n++) begin
      step();
      if (rv_a) begin
        got_c[nresp]  = rc_a;
        got_id[nresp] = rid_a;
        nresp++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_count", nresp, 4);
    for (int i = 0; i < nresp; i++) begin
      chk("rr_id", {31'b0, got_id[i]}, {31'b0, i[0]});
      chk("rr_c", got_c[i], i[0] ? 32'hF0000000 : 32'h22);
    end
    for (int n = 0; n < 3; n++) step();

    for (int i = 0; i < 12; i++)
      do_op(tv[i].id, tv[i].a, tv[i].b, tv[i].m, tv[i].c,
            tv[i].l0, tv[i].l1);

    // Response held off: outputs frozen, no grants.
    resp_ready = 1'b0;
    req0_a = 32'h0F0F0F0F; req0_b = 32'd5; req0_mode = 2'b01;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("stall_valid", rv_a, 1);
    hold_c = ref_c(32'h0F0F0F0F, 32'd5, 2'b01);
    hold_id = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 32'h3; req1_b = 32'd2; req1_mode = 2'b00;
    for (int n = 0; n < 10; n++) begin
      chk("stall_c", rc_a, hold_c);
      chk("stall_id", rid_a, hold_id);
      chk("stall_rdy", {rdy0_a, rdy1_a}, 0);
      chk("stall_busy", busy_a, 1);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("pulse_idle", busy_a, 0);
    chk("pulse_valid", rv_a, 0);
    chk("pulse_rdy1", rdy1_a, 1);
    step();
    chk("pulse_accept", busy_a, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp_ready = 1'b1;
    for (int n = 0; n < 10; n++) step();

    // Reset in the middle of SHIFT stage 2.
    req1_a = 32'hDEADBEEF; req1_b = 32'd7; req1_mode = 2'b10;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    step();
    #3;
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    chk("mid_busy", busy_a, 0);
    chk("mid_valid", rv_a, 0);
    chk("mid_c", rc_a, 0);
    chk("mid_id", rid_a, 0);
    chk("mid_rdy", {rdy0_a, rdy1_a}, 0);
    req0_valid = 1'b0;
    step();
    rst = 1'b0;
    stale = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (rv_a || rv_b) stale = 1'b1;
      step();
    end
    chk("no_stale", stale, 0);
    do_op(1'b1, 32'hDEADBEEF, 32'd7, 2'b10,
          ref_c(32'hDEADBEEF, 32'd7, 2'b10), 6, 6);

    // Random operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rid = 1'($urandom_range(0, 1));
      ra  = $urandom;
      rb  = $urandom_range(0, 40);
      rm  = 2'($urandom_range(0, 3));
      do_op(rid, ra, rb, rm, ref_c(ra, rb, rm),
            ref_lat(rb, 1'b0), ref_lat(rb, 1'b1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
